// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: bundles the two-requester request/response channels and the FPU-side
// control/data signals of fpu_arbiter.
//   slave  modport: the arbiter's view (requests and FPU results in, grants/responses/FPU
//                   controls out).
//   master modport: the environment's view (requesters plus the FPU itself).
// Signals:
//   req_valid/req_ready [1:0], req_op [5:0], req_a/req_b [63:0], req_rnd [5:0]
//   rsp_valid/rsp_ready [1:0], rsp_data [31:0], rsp_flags [8:0]
//   fpu_in1/fpu_in2 [31:0], fpu_opcode/fpu_round [2:0], fpu_act, fpu_rstp
//   fpu_out [31:0], fpu_flags [7:0], fpu_done
interface fpu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_rnd;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [8:0]  rsp_flags;
  logic [31:0] fpu_in1;
  logic [31:0] fpu_in2;
  logic [2:0]  fpu_opcode;
  logic [2:0]  fpu_round;
  logic        fpu_act;
  logic        fpu_rstp;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
  logic        fpu_done;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rnd, rsp_ready, fpu_out, fpu_flags, fpu_done,
    output req_ready, rsp_valid, rsp_data, rsp_flags, fpu_in1, fpu_in2, fpu_opcode, fpu_round,
           fpu_act, fpu_rstp
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rnd, rsp_ready, fpu_out, fpu_flags, fpu_done,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, fpu_in1, fpu_in2, fpu_opcode, fpu_round,
           fpu_act, fpu_rstp
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter sharing one FPU between two requesters.
// A granted request is latched, the FPU is held in reset for one CLR cycle, activated in
// RUN until a qualified fpu_done, and the registered result is offered in RESP until the
// granted requester accepts it.
// Ports:
//   clk  - clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - fpu_arbiter_if.slave (requester channels and FPU interface)
// Parameter TIMEOUT (2..255): RUN-cycle limit when the timeout feature is built.
// Optional feature: define FPU_ARB_TIMEOUT_EN to abort a stuck FPU operation with a NaN
// result and the timeout flag set; without it RUN waits indefinitely.
module fpu_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic         clk,
  input logic         rstn,
  fpu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StResp} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        gnt_q, gnt_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  rnd_q, rnd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [8:0]  flags_q, flags_d;

  logic        gnt_idx;
  logic        done_ok;
  logic [1:0]  ready;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  // With both valid the pointer decides; with one valid, bit 0 clear means requester 1.
  assign gnt_idx = (bus.req_valid == 2'b11) ? prio_q : ~bus.req_valid[0];
  // The first RUN cycle may still see a done left over from before the FPU reset.
  assign done_ok = bus.fpu_done && (cnt_q != 8'd0);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    rnd_d   = rnd_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    flags_d = flags_q;
    ready   = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          ready[gnt_idx] = 1'b1;
          gnt_d   = gnt_idx;
          op_d    = gnt_idx ? bus.req_op[5:3]   : bus.req_op[2:0];
          rnd_d   = gnt_idx ? bus.req_rnd[5:3]  : bus.req_rnd[2:0];
          a_d     = gnt_idx ? bus.req_a[63:32]  : bus.req_a[31:0];
          b_d     = gnt_idx ? bus.req_b[63:32]  : bus.req_b[31:0];
          state_d = StClr;
        end
      end
      StClr: begin
        cnt_d   = 8'd0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 8'd1;
        if (done_ok) begin
          data_d  = bus.fpu_out;
          flags_d = {bus.fpu_flags, 1'b0};
          state_d = StResp;
`ifdef FPU_ARB_TIMEOUT_EN
        end else if (cnt_q == CntMax) begin
          data_d  = 32'h7FC0_0000;
          flags_d = 9'b0_0000_1001;
          state_d = StResp;
`endif
        end
      end
      StResp: begin
        if (bus.rsp_ready[gnt_q]) begin
          prio_d  = ~gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= 3'd0;
      rnd_q   <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      flags_q <= 9'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      rnd_q   <= rnd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    // IDLE grant is combinational from req_valid, so it must be masked during reset.
    bus.req_ready  = rstn ? ready : 2'b00;
    bus.rsp_valid  = 2'b00;
    bus.rsp_data   = 32'd0;
    bus.rsp_flags  = 9'd0;
    bus.fpu_in1    = 32'd0;
    bus.fpu_in2    = 32'd0;
    bus.fpu_opcode = 3'd0;
    bus.fpu_round  = 3'd0;
    bus.fpu_act    = (state_q == StRun);
    bus.fpu_rstp   = (state_q == StIdle) || (state_q == StClr);
    if (state_q != StIdle) begin
      bus.fpu_in1    = a_q;
      bus.fpu_in2    = b_q;
      bus.fpu_opcode = op_q;
      bus.fpu_round  = rnd_q;
    end
    if (state_q == StResp) begin
      bus.rsp_valid = gnt_q ? 2'b10 : 2'b01;
      bus.rsp_data  = data_q;
      bus.rsp_flags = flags_q;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed, table-driven bench for fpu_arbiter with a small FPU model.
module tb_fpu_arbiter;
  localparam int unsigned Timeout = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fpu_arbiter_if bus ();

  fpu_arbiter #(.TIMEOUT(Timeout)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // FPU model: done after m_lat active cycles following its reset. Table mode returns the
  // vector's result only if the forwarded operands match; sum mode returns in1+in2.
  int unsigned m_lat = 1;
  logic        m_nodone = 1'b0;
  logic        m_sum = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]  m_op = '0, m_rnd = '0;
  logic [7:0]  m_flags = '0;
  logic [7:0]  act_cnt;
  logic        m_match;

  always_ff @(posedge clk) begin
    if (bus.fpu_rstp)     act_cnt <= 8'd0;
    else if (bus.fpu_act) act_cnt <= act_cnt + 8'd1;
  end

  assign m_match = (bus.fpu_in1 == m_a) && (bus.fpu_in2 == m_b) &&
                   (bus.fpu_opcode == m_op) && (bus.fpu_round == m_rnd);
  assign bus.fpu_done  = bus.fpu_act && !m_nodone && (32'(act_cnt) >= m_lat);
  assign bus.fpu_out   = m_sum ? (bus.fpu_in1 + bus.fpu_in2) : (m_match ? m_res : 32'hDEAD_BEEF);
  assign bus.fpu_flags = m_sum ? 8'h00 : (m_match ? m_flags : 8'h5A);

  typedef struct {
    logic        idx;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic [31:0] res;
    logic [7:0]  fflags;
    int unsigned lat;
  } vec_t;

  vec_t vecs[6];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input logic idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] rnd);
    if (idx) begin
      bus.req_op[5:3] = op; bus.req_a[63:32] = a; bus.req_b[63:32] = b; bus.req_rnd[5:3] = rnd;
    end else begin
      bus.req_op[2:0] = op; bus.req_a[31:0] = a; bus.req_b[31:0] = b; bus.req_rnd[2:0] = rnd;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_fpu_rstp", bus.fpu_rstp, 1'b1);
    check("rst_fpu_act", bus.fpu_act, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_flags", bus.rsp_flags, 9'd0);
    check("rst_fpu_in1", bus.fpu_in1, 32'd0);
    check("rst_fpu_opcode", bus.fpu_opcode, 3'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rstn = 1'b1;
  endtask

  // Single-requester transaction; request held valid until the response handshake.
  task automatic run_txn(input vec_t v);
    int k;
    int lat_exp;
    logic seen;
    logic [1:0] oh;
    oh = v.idx ? 2'b10 : 2'b01;
    m_sum = 1'b0; m_nodone = 1'b0; m_lat = v.lat;
    m_a = v.a; m_b = v.b; m_op = v.op; m_rnd = v.rnd; m_res = v.res; m_flags = v.fflags;
    @(negedge clk);
    bus.rsp_ready = 2'b11;
    set_slot(v.idx, v.op, v.a, v.b, v.rnd);
    set_slot(~v.idx, 3'd6, ~v.a, ~v.b, ~v.rnd);
    bus.req_valid = oh;
    #1;
    check("idle_req_ready", bus.req_ready, oh);
    check("idle_fpu_rstp", bus.fpu_rstp, 1'b1);
    check("idle_fpu_in1", bus.fpu_in1, 32'd0);
    lat_exp = (v.lat <= 1) ? 4 : 3 + int'(v.lat);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk); #1;
      k++;
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
      else if (k == 1) begin
        check("clr_fpu_rstp", bus.fpu_rstp, 1'b1);
        check("clr_fpu_act", bus.fpu_act, 1'b0);
        check("clr_fpu_in1", bus.fpu_in1, v.a);
        check("clr_fpu_in2", bus.fpu_in2, v.b);
        check("clr_fpu_opcode", bus.fpu_opcode, v.op);
        check("clr_fpu_round", bus.fpu_round, v.rnd);
        check("busy_req_ready", bus.req_ready, 2'b00);
      end else if (k == 2) begin
        check("run_fpu_act", bus.fpu_act, 1'b1);
        check("run_fpu_rstp", bus.fpu_rstp, 1'b0);
      end
    end
    check("rsp_seen", seen, 1'b1);
    check("rsp_latency", k, lat_exp);
    check("rsp_valid", bus.rsp_valid, oh);
    check("rsp_data", bus.rsp_data, v.res);
    check("rsp_flags", bus.rsp_flags, {v.fflags, 1'b0});
    check("resp_fpu_in1", bus.fpu_in1, v.a);
    check("resp_fpu_rstp", bus.fpu_rstp, 1'b0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("post_rsp_valid", bus.rsp_valid, 2'b00);
    check("post_rsp_data", bus.rsp_data, 32'd0);
    check("post_fpu_rstp", bus.fpu_rstp, 1'b1);
    check("post_fpu_in1", bus.fpu_in1, 32'd0);
  endtask

  // Both requesters held valid; expects grant idx now, then response data exp_data.
  task automatic serve(input logic idx, input logic [31:0] exp_data);
    int k;
    logic seen;
    check("cont_req_ready", bus.req_ready, idx ? 2'b10 : 2'b01);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk); #1;
      k++;
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
    end
    check("cont_rsp_seen", seen, 1'b1);
    check("cont_rsp_valid", bus.rsp_valid, idx ? 2'b10 : 2'b01);
    check("cont_rsp_data", bus.rsp_data, exp_data);
    @(negedge clk); #1;
  endtask

  task automatic wait_rsp(output int k, output logic seen);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 60) begin
      @(negedge clk); #1;
      k++;
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic seen;
    logic [31:0] held;

    vecs[0] = '{1'b0, 3'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 8'h00, 1};
    vecs[1] = '{1'b1, 3'd1, 32'h4000_0000, 32'h4040_0000, 3'd0, 32'h40C0_0000, 8'h00, 1};
    vecs[2] = '{1'b0, 3'd2, 32'h3F80_0000, 32'h0000_0000, 3'd1, 32'h7F80_0000, 8'h01, 3};
    vecs[3] = '{1'b1, 3'd4, 32'h3F80_0000, 32'h4000_0000, 3'd2, 32'h0000_0000, 8'h20, 0};
    vecs[4] = '{1'b0, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 3'd7, 32'hCAFE_BABE, 8'hFF, 2};
    vecs[5] = '{1'b1, 3'd5, 32'h0BAD_F00D, 32'h0000_0001, 3'd3, 32'h0000_0001, 8'h84, 1};

    rstn = 1'b0;
    bus.req_valid = 2'b00; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_rnd = '0;
    bus.rsp_ready = 2'b00;
    do_reset();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Contention straight after reset: 0, 1, then 0 again.
    do_reset();
    m_sum = 1'b1; m_nodone = 1'b0; m_lat = 1;
    @(negedge clk);
    set_slot(1'b0, 3'd0, 32'h0000_0100, 32'h0000_0023, 3'd0);
    set_slot(1'b1, 3'd1, 32'h0000_2000, 32'h0000_0005, 3'd1);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    #1;
    serve(1'b0, 32'h0000_0123);
    serve(1'b1, 32'h0000_2005);
    serve(1'b0, 32'h0000_0123);
    bus.req_valid = 2'b00;

    // Backpressure: prio now 1; only the other requester's rsp_ready is high.
    @(negedge clk);
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b11;
    #1;
    check("bp_req_ready", bus.req_ready, 2'b10);
    wait_rsp(k, seen);
    check("bp_rsp_seen", seen, 1'b1);
    held = 32'h0000_2005;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check("bp_rsp_valid", bus.rsp_valid, 2'b10);
      check("bp_rsp_data", bus.rsp_data, held);
      check("bp_req_ready", bus.req_ready, 2'b00);
    end
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    #1;
    check("bp_rsp_valid_last", bus.rsp_valid, 2'b10);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("bp_idle_rsp_valid", bus.rsp_valid, 2'b00);
    check("bp_idle_fpu_rstp", bus.fpu_rstp, 1'b1);

    // Stuck FPU on requester 0.
    m_sum = 1'b0; m_nodone = 1'b1;
    m_a = 32'h4100_0000; m_b = 32'h4000_0000; m_op = 3'd3; m_rnd = 3'd0;
    m_res = 32'h4040_0000; m_flags = 8'h04;
    @(negedge clk);
    bus.rsp_ready = 2'b11;
    set_slot(1'b0, 3'd3, 32'h4100_0000, 32'h4000_0000, 3'd0);
    bus.req_valid = 2'b01;
    #1;
    check("to_req_ready", bus.req_ready, 2'b01);
`ifdef FPU_ARB_TIMEOUT_EN
    wait_rsp(k, seen);
    check("to_rsp_seen", seen, 1'b1);
    check("to_latency", k, 2 + int'(Timeout));
    check("to_rsp_valid", bus.rsp_valid, 2'b01);
    check("to_rsp_data", bus.rsp_data, 32'h7FC0_0000);
    check("to_rsp_flags", bus.rsp_flags, 9'b0_0000_1001);
`else
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
    end
    check("nto_no_rsp", seen, 1'b0);
    check("nto_still_run", bus.fpu_act, 1'b1);
    m_nodone = 1'b0;
    wait_rsp(k, seen);
    check("nto_rsp_seen", seen, 1'b1);
    check("nto_latency", k, 1);
    check("nto_rsp_data", bus.rsp_data, 32'h4040_0000);
    check("nto_rsp_flags", bus.rsp_flags, 9'b0_0000_1000);
`endif
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("to_post_rsp_valid", bus.rsp_valid, 2'b00);

    // Reset in the middle of RUN abandons the operation; prio was 1 before it.
    m_nodone = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    check("mr_req_ready", bus.req_ready, 2'b01);
    repeat (3) @(negedge clk);
    #1;
    check("mr_in_run", bus.fpu_act, 1'b1);
    #1 rstn = 1'b0;
    #1;
    check("mr_fpu_rstp", bus.fpu_rstp, 1'b1);
    check("mr_fpu_act", bus.fpu_act, 1'b0);
    check("mr_fpu_in1", bus.fpu_in1, 32'd0);
    check("mr_fpu_in2", bus.fpu_in2, 32'd0);
    check("mr_fpu_opcode", bus.fpu_opcode, 3'd0);
    check("mr_fpu_round", bus.fpu_round, 3'd0);
    check("mr_rsp_valid", bus.rsp_valid, 2'b00);
    check("mr_rsp_data", bus.rsp_data, 32'd0);
    check("mr_req_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    bus.req_valid = 2'b00;
    m_nodone = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
    end
    check("mr_no_rsp", seen, 1'b0);
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    check("mr_prio_reset", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
